// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the round-robin comparator arbiter.
// The response counter is enabled with the CMP_ARB_STATS_EN macro.
package cmp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_IDW   = 2;
    localparam int STATS_W   = 16;

endpackage

// File: rtl/n_bit_comparator.sv
// Unsigned magnitude comparator; reset forces all flags low.
module n_bit_comparator #(
    parameter int WIDTH = 4
) (
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gr,
    output logic             ls,
    output logic             eq
);

    always_comb begin
        gr = 1'b0;
        ls = 1'b0;
        eq = 1'b0;
        if (!rst) begin
            gr = (a > b);
            ls = (a < b);
            eq = (a == b);
        end
    end

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid index at or above the
// pointer, wrapping modulo NREQ.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  winner,
    output logic            any_valid
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [IDW:0] w_idx;

    always_comb begin
        grant     = '0;
        winner    = '0;
        any_valid = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, ptr} + (IDW+1)'(k);
            if (w_idx >= NREQ_W) begin
                w_idx = w_idx - NREQ_W;
            end
            if (!any_valid && valid[w_idx[IDW-1:0]]) begin
                any_valid                = 1'b1;
                grant[w_idx[IDW-1:0]]    = 1'b1;
                winner                   = w_idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/cmp_rr_arbiter.sv
// Round-robin arbiter sharing one n_bit_comparator among NREQ requesters.
// Optional response counter (cmp_count) enabled by defining CMP_ARB_STATS_EN.
module cmp_rr_arbiter
    import cmp_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int IDW   = DEF_IDW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_gr,
    output logic              rsp_ls,
    output logic              rsp_eq,
    output logic [1:0]        dbg_state
`ifdef CMP_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] cmp_count
`endif
);

    // Handshakes: a request transfers on req_valid[i] & req_ready[i] at a
    // rising edge; a response transfers on rsp_valid & rsp_ready. Once
    // rsp_valid is high the payload holds until the transfer completes.

    arb_state_t r_state;
    arb_state_t w_next;

    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [IDW-1:0]   r_id;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic             r_rsp_gr;
    logic             r_rsp_ls;
    logic             r_rsp_eq;

    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_win;
    logic             w_any;
    logic [IDW-1:0]   w_ptr_next;
    logic             w_gr;
    logic             w_ls;
    logic             w_eq;
    logic [WIDTH-1:0] w_a_arr [NREQ];
    logic [WIDTH-1:0] w_b_arr [NREQ];

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .valid     (req_valid),
        .ptr       (r_ptr),
        .grant     (w_grant),
        .winner    (w_win),
        .any_valid (w_any)
    );

    n_bit_comparator #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .rst (rst),
        .a   (r_a),
        .b   (r_b),
        .gr  (w_gr),
        .ls  (w_ls),
        .eq  (w_eq)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_a_arr[i] = req_a[i*WIDTH +: WIDTH];
            w_b_arr[i] = req_b[i*WIDTH +: WIDTH];
        end
    end

    // Wrap explicitly so non-power-of-two NREQ never reaches an unused index.
    assign w_ptr_next = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    req_ready = w_grant;
                    w_next    = ST_CMP;
                end
            end
            ST_CMP: begin
                w_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_gr    <= 1'b0;
            r_rsp_ls    <= 1'b0;
            r_rsp_eq    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_a   <= w_a_arr[w_win];
                        r_b   <= w_b_arr[w_win];
                        r_id  <= w_win;
                        r_ptr <= w_ptr_next;
                    end
                end
                ST_CMP: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_id    <= r_id;
                    r_rsp_gr    <= w_gr;
                    r_rsp_ls    <= w_ls;
                    r_rsp_eq    <= w_eq;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CMP_ARB_STATS_EN
    logic [STATS_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (r_rsp_valid && rsp_ready && (r_count != {STATS_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign cmp_count = r_count;
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_gr    = r_rsp_gr;
    assign rsp_ls    = r_rsp_ls;
    assign rsp_eq    = r_rsp_eq;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cmp_rr_arbiter.sv
// Self-checking bench for cmp_rr_arbiter: a negedge monitor predicts grants
// and pushes expected responses, which are popped on each response transfer.
module tb_cmp_rr_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;
  localparam int RW    = IDW + 3;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ*WIDTH-1:0]   req_a;
  logic [NREQ*WIDTH-1:0]   req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [IDW-1:0]          rsp_id;
  logic                    rsp_gr;
  logic                    rsp_ls;
  logic                    rsp_eq;
  logic [1:0]              dbg_state;
`ifdef CMP_ARB_STATS_EN
  logic [15:0]             cmp_count;
`endif

  cmp_rr_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .IDW   (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gr    (rsp_gr),
    .rsp_ls    (rsp_ls),
    .rsp_eq    (rsp_eq),
    .dbg_state (dbg_state)
`ifdef CMP_ARB_STATS_EN
    ,
    .cmp_count (cmp_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [RW-1:0] exp_q[$];
  int n_checks;
  int n_errors;
  int m_ptr;
  bit m_busy;
  int cyc;
  int grant_cyc;
  int last_grant_cyc;
  int last_win;
  int n_grants;
  bit tput_en;
  bit prev_hold;
  logic [RW:0] held;
  int m_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      int w;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [RW-1:0] e;
      cyc++;
`ifdef CMP_ARB_STATS_EN
      check("cmp_count", 32'(cmp_count), 32'(m_count));
`endif
      if (prev_hold) begin
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_payload", 32'({rsp_valid, rsp_id, rsp_gr, rsp_ls, rsp_eq}), 32'(held));
      end
      if (m_busy && cyc == grant_cyc + 2) begin
        check("rsp_latency", 32'(rsp_valid), 32'd1);
      end
      if (rsp_valid) begin
        check("onehot_flags", 32'(rsp_gr) + 32'(rsp_ls) + 32'(rsp_eq), 32'd1);
      end
      if (m_busy) begin
        check("ready_busy", 32'(req_ready), 32'd0);
      end else if (req_valid != '0) begin
        w = model_pick(req_valid, m_ptr);
        check("grant", 32'(req_ready), 32'(1) << w);
        a = req_a[w*WIDTH +: WIDTH];
        b = req_b[w*WIDTH +: WIDTH];
        e = {IDW'(w), a > b, a < b, a == b};
        exp_q.push_back(e);
        if (tput_en && last_grant_cyc >= 0) begin
          check("grant_period", 32'(cyc - last_grant_cyc), 32'd3);
        end
        m_ptr = (w + 1) % NREQ;
        m_busy = 1'b1;
        grant_cyc = cyc;
        last_grant_cyc = cyc;
        last_win = w;
        n_grants++;
      end else begin
        check("ready_idle", 32'(req_ready), 32'd0);
      end
      if (rsp_valid && rsp_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rsp_payload", 32'({rsp_id, rsp_gr, rsp_ls, rsp_eq}), 32'(e));
        end
        m_busy = 1'b0;
        if (m_count < 16'hFFFF) m_count++;
      end
      prev_hold = rsp_valid && !rsp_ready;
      held = {rsp_valid, rsp_id, rsp_gr, rsp_ls, rsp_eq};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic model_clear();
    exp_q.delete();
    m_ptr = 0;
    m_busy = 1'b0;
    prev_hold = 1'b0;
    m_count = 0;
    last_grant_cyc = -100;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_ops(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
  endtask

  task automatic wait_grant(input int max_cyc);
    int g0;
    int n;
    g0 = n_grants;
    n = 0;
    while (n_grants == g0 && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    if (n_grants == g0) check("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while ((m_busy || exp_q.size() != 0) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_busy || exp_q.size() != 0) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    set_ops(idx, a, b);
    req_valid = NREQ'(1) << idx;
    wait_grant(20);
    req_valid = '0;
    wait_idle(20);
  endtask

  initial begin
    #200000;
    check("watchdog", 32'd1, 32'd0);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc = 0;
    grant_cyc = 0;
    n_grants = 0;
    last_win = -1;
    tput_en = 1'b0;
    held = '0;
    req_a = '0;
    req_b = '0;
    reset_dut();

    // reset state
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_flags", 32'({rsp_gr, rsp_ls, rsp_eq}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // single request, then directed gr/ls/eq corners
    rsp_ready = 1'b1;
    issue(2, 4'd7, 4'd3);
    check("single_win", 32'(last_win), 32'd2);
    issue(1, 4'd9, 4'd9);
    issue(0, 4'd0, 4'd15);
    issue(3, 4'd15, 4'd0);
    issue(3, 4'd5, 4'd5);
    check("flags_hold_after", 32'({rsp_gr, rsp_ls, rsp_eq}), 32'b001);

    // fairness with all requesters active
    reset_dut();
    rsp_ready = 1'b1;
    tput_en = 1'b1;
    req_valid = '1;
    for (int g = 0; g < 13; g++) begin
      for (int i = 0; i < NREQ; i++) set_ops(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      wait_grant(10);
      if (g < 5) check("fair_order", 32'(last_win), 32'(g % NREQ));
    end
    tput_en = 1'b0;
    req_valid = '0;
    wait_idle(20);

    // backpressure
    rsp_ready = 1'b0;
    set_ops(0, 4'd2, 4'd11);
    set_ops(1, 4'd12, 4'd4);
    req_valid = 4'b0011;
    wait_grant(10);
    repeat (7) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_grant(10);
    req_valid = '0;
    wait_idle(20);

    // reset during CMP
    req_valid = 4'b0001;
    set_ops(0, 4'd6, 4'd1);
    wait_grant(10);
    rst = 1'b1;
    req_valid = '0;
    model_clear();
    #1;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    req_valid = 4'b1000;
    set_ops(3, 4'd8, 4'd8);
    wait_grant(10);
    check("midrst_win", 32'(last_win), 32'd3);
    req_valid = '0;
    wait_idle(20);

    // random traffic with random backpressure
    for (int c = 0; c < 300; c++) begin
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      rsp_ready = 1'($urandom_range(0, 1));
      for (int i = 0; i < NREQ; i++) set_ops(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      @(posedge clk); #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(20);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
